sopc_2_cpu_jtag_debug_cmd_queue: RTL and testbench

SOPC_2_CPU_JTAG_DEBUG_CMD_QUEUE -- requirements
Module: sopc_2_cpu_jtag_debug_cmd_queue

---
 rtl/sopc_2_cpu_jtag_debug_cmd_queue.sv | 141 ++++++++++++++
 tb/tb_sopc_2_cpu_jtag_debug_cmd_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_2_cpu_jtag_debug_cmd_queue.sv
// JTAG debug command queue: synchronizes the TCK-domain update strobes, queues {ir, sr}
// commands and issues per-channel action strobes on pop. Optional macro: DBG_CMD_OVF_COUNT_EN.
module sopc_2_cpu_jtag_debug_cmd_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    input  logic                       cmd_ready,
    output logic                       cmd_valid,
    output logic [IR_W-1:0]            cmd_ir,
    output logic [DATA_W-1:0]          jdo,
    output logic [(2**IR_W)-1:0]       take_action,
    output logic [(2**IR_W)-1:0]       take_no_action,
    output logic                       ir_update,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf,
    output logic [7:0]                 ovf_count
);
    localparam int NCH   = 2**IR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int CMD_W = IR_W + DATA_W;

    function automatic logic [NCH-1:0] onehot(input logic [IR_W-1:0] idx);
        logic [NCH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Stage p0/p1: synchronizers preset to 1 so a level held across reset never looks like an edge
    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_dly, uir_dly;
    logic                   udr_edge, uir_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync <= '1;
            uir_sync <= '1;
            udr_dly  <= 1'b1;
            uir_dly  <= 1'b1;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_dly  <= udr_sync[SYNC_STAGES-1];
            uir_dly  <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_dly;
    assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_dly;

    // Stage p2: queue update, pop outputs and ir_update pulse
    logic [CMD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CMD_W-1:0]  head;
    logic [DATA_W-1:0] head_sr;
    logic              full, pop, push, drop;

    assign head      = mem[rd_ptr];
    assign head_sr   = head[DATA_W-1:0];
    assign cmd_ir    = head[CMD_W-1:DATA_W];
    assign cmd_valid = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    // A pop frees the head slot in the same edge, so a full queue can still take a push.
    assign push      = udr_edge & (~full | pop);
    assign drop      = udr_edge & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            ir_update      <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            ir_update      <= uir_edge;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                jdo    <= head_sr;
                if (head_sr[ACT_BIT]) begin
                    take_action <= onehot(cmd_ir);
                end else begin
                    take_no_action <= onehot(cmd_ir);
                end
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef DBG_CMD_OVF_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] ovf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf_cnt <= sat_inc8(ovf_cnt);
        end
    end

    assign ovf_count = ovf_cnt;
`else
    assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_sopc_2_cpu_jtag_debug_cmd_queue.sv
// Bench for the debug command queue: directed vector table, corner-case sequences and
// randomized traffic scored against an event-scheduled queue model.
module tb_sopc_2_cpu_jtag_debug_cmd_queue;
    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ACT_BIT     = 34;
    localparam int NCH         = 2**IR_W;
    localparam int LVL_W       = $clog2(DEPTH+1);
`ifdef DBG_CMD_OVF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, vs_udr, vs_uir, cmd_ready;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_valid, ir_update, ovf;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] jdo;
    logic [NCH-1:0]    take_action, take_no_action;
    logic [LVL_W-1:0]  level;
    logic [7:0]        ovf_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sopc_2_cpu_jtag_debug_cmd_queue #(
        .DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .ir_update(ir_update), .level(level), .ovf(ovf), .ovf_count(ovf_count)
    );

    // Reference model: a rising input level seen at edge k becomes an event at edge k+SYNC_STAGES.
    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] sr;
    } cmd_t;

    cmd_t              mq[$];
    int                udr_due[$];
    int                uir_due[$];
    int                cyc = 0;
    bit                prev_udr = 1'b1, prev_uir = 1'b1;
    logic [DATA_W-1:0] m_jdo = '0;
    logic [NCH-1:0]    m_ta = '0, m_tna = '0;
    bit                m_irup = 1'b0, m_ovf = 1'b0;
    int                m_cnt = 0;
    bit                m_pop, m_push, m_full;
    cmd_t              m_head;
    bit                chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_ta   = '0;
        m_tna  = '0;
        m_irup = 1'b0;
        if (reset) begin
            mq.delete();
            udr_due.delete();
            uir_due.delete();
            m_jdo    = '0;
            m_ovf    = 1'b0;
            m_cnt    = 0;
            prev_udr = 1'b1;
            prev_uir = 1'b1;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && cmd_ready;
            m_push = (udr_due.size() > 0) && (udr_due[0] == cyc);
            if (m_push) void'(udr_due.pop_front());
            if ((uir_due.size() > 0) && (uir_due[0] == cyc)) begin
                void'(uir_due.pop_front());
                m_irup = 1'b1;
            end
            if (m_pop) begin
                m_head = mq.pop_front();
                m_jdo  = m_head.sr;
                if (m_head.sr[ACT_BIT]) m_ta[m_head.ir] = 1'b1;
                else                    m_tna[m_head.ir] = 1'b1;
            end
            if (m_push) begin
                if (m_full && !m_pop) begin
                    m_ovf = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    mq.push_back({ir_in, sr});
                end
            end
            if (vs_udr && !prev_udr) udr_due.push_back(cyc + SYNC_STAGES);
            if (vs_uir && !prev_uir) uir_due.push_back(cyc + SYNC_STAGES);
            prev_udr = vs_udr;
            prev_uir = vs_uir;
        end
    end

    logic [61:0]     exp_v, act_v;
    logic [IR_W-1:0] exp_ir;
    logic [7:0]      exp_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ir  = (mq.size() > 0) ? mq[0].ir : '0;
            exp_cnt = CNT_EN ? 8'(m_cnt) : 8'd0;
            exp_v   = {mq.size() > 0, LVL_W'(mq.size()), exp_ir, m_jdo, m_ta, m_tna,
                       m_irup, m_ovf, exp_cnt};
            act_v   = {cmd_valid, level, cmd_valid ? cmd_ir : {IR_W{1'b0}}, jdo,
                       take_action, take_no_action, ir_update, ovf, ovf_count};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves enough low time for the push to land before sr changes.
    task automatic pulse_udr(input logic [IR_W-1:0] i, input logic [DATA_W-1:0] d);
        vs_udr = 1'b1;
        ir_in  = i;
        sr     = d;
        tick(1);
        vs_udr = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
    endtask

    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
        logic [NCH-1:0]    exp_ta;
        logic [NCH-1:0]    exp_tna;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'd2, 38'h01_2345_6789, 4'b0000, 4'b0100};
        vecs[1] = '{2'd2, 38'h05_2345_6789, 4'b0100, 4'b0000};
        vecs[2] = '{2'd1, 38'h00_0000_0001, 4'b0000, 4'b0010};
        vecs[3] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
        vecs[4] = '{2'd0, 38'h04_0000_0000, 4'b0001, 4'b0000};
        vecs[5] = '{2'd0, 38'h3B_FFFF_FFFF, 4'b0000, 4'b0001};

        reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
        ir_in = '0; sr = '0;
        tick(3);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_strobes", 64'({take_action, take_no_action, ir_update}), 64'd0);
        chk("rst_ovf", 64'({ovf, ovf_count}), 64'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        tick(3);

        // Single-command latency and strobe decode
        for (int v = 0; v < 6; v++) begin
            vs_udr = 1'b1; ir_in = vecs[v].ir; sr = vecs[v].data;
            tick(1);
            chk("lat_k", 64'(cmd_valid), 64'd0);
            tick(1);
            chk("lat_k1", 64'(cmd_valid), 64'd0);
            tick(1);
            chk("lat_k2_valid", 64'(cmd_valid), 64'd1);
            chk("lat_k2_ir", 64'(cmd_ir), 64'(vecs[v].ir));
            cmd_ready = 1'b1; vs_udr = 1'b0;
            tick(1);
            chk("pop_jdo", 64'(jdo), 64'(vecs[v].data));
            chk("pop_ta", 64'(take_action), 64'(vecs[v].exp_ta));
            chk("pop_tna", 64'(take_no_action), 64'(vecs[v].exp_tna));
            chk("pop_level", 64'(level), 64'd0);
            cmd_ready = 1'b0;
            tick(1);
            chk("strobe_1cyc", 64'({take_action, take_no_action}), 64'd0);
            chk("jdo_hold", 64'(jdo), 64'(vecs[v].data));
            tick(2);
        end

        // Overflow: five pushes into a four-entry queue, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++) pulse_udr(IR_W'(i), DATA_W'(100 + i));
        tick(2);
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_count1", 64'(ovf_count), CNT_EN ? 64'd1 : 64'd0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("drain_order", 64'(jdo), 64'(100 + i));
        end
        cmd_ready = 1'b0;
        tick(1);
        chk("drain_empty", 64'({cmd_valid, level}), 64'd0);
        chk("drain_ovf_sticky", 64'(ovf), 64'd1);

        // Full queue with coincident push and pop
        do_reset();
        for (int i = 0; i < 4; i++) pulse_udr(IR_W'(i), DATA_W'(10 + i));
        chk("full_level", 64'(level), 64'd4);
        vs_udr = 1'b1; ir_in = 2'd1; sr = DATA_W'(14);
        tick(1);
        vs_udr = 1'b0;
        tick(1);
        cmd_ready = 1'b1;
        tick(1);
        chk("coinc_level", 64'(level), 64'd4);
        chk("coinc_ovf", 64'(ovf), 64'd0);
        chk("coinc_oldest", 64'(jdo), 64'd10);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("coinc_order", 64'(jdo), 64'(11 + i));
        end
        cmd_ready = 1'b0;
        tick(1);
        chk("coinc_empty", 64'(level), 64'd0);

        // vs_udr held high across reset release produces no push
        vs_udr = 1'b1;
        reset  = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("held_no_push", 64'({cmd_valid, level}), 64'd0);
        vs_udr = 1'b0;
        tick(2);

        // Reset mid-operation with three queued commands
        for (int i = 0; i < 4; i++) pulse_udr(2'd3, DATA_W'(50 + i));
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("mid_level3", 64'(level), 64'd3);
        chk("mid_jdo", 64'(jdo), 64'd50);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_clear", 64'({cmd_valid, level, jdo}), 64'd0);
        reset = 1'b0;
        tick(3);

        // ir_update pulse leaves the queue alone
        pulse_udr(2'd1, DATA_W'(7));
        vs_uir = 1'b1;
        tick(1);
        vs_uir = 1'b0;
        begin
            int highs;
            highs = 0;
            for (int i = 0; i < 6; i++) begin
                tick(1);
                if (ir_update) highs++;
            end
            chk("ir_update_1cyc", 64'(highs), 64'd1);
        end
        chk("ir_update_level", 64'(level), 64'd1);

        // 300 drops saturate the counter
        for (int i = 0; i < 303; i++) pulse_udr(2'd0, DATA_W'(i));
        chk("sat_level", 64'(level), 64'd4);
        chk("sat_ovf", 64'(ovf), 64'd1);
        chk("sat_count", 64'(ovf_count), CNT_EN ? 64'd255 : 64'd0);

        // Randomized traffic, scored by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            vs_udr    = ($urandom_range(0, 3) == 0);
            vs_uir    = ($urandom_range(0, 7) == 0);
            cmd_ready = ($urandom_range(0, 2) == 0);
            ir_in     = IR_W'($urandom);
            sr        = DATA_W'({$urandom, $urandom});
            reset     = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        reset = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b1;
        tick(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
